regfile_operand_fetch: RTL and testbench
========================================

Name: regfile_operand_fetch

Overview:
- Register file plus operand-fetch sequencer that sits directly upstream of the shifter in the lab datapath.
- Holds 8 x 16-bit general registers and, on a start pulse, reads Rm into operand register B and Rn into operand register A.
- Signals completion with a one-cycle done pulse.
- b_out drives the shifter's 16-bit data input; a_out goes to the ALU A side.

Parameters:
- DATA_W, 16, register and operand width in bits
- NREGS, 8, number of general registers; REG_AW = $clog2(NREGS) = 3, derived, not overridable

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- write  input  1  register-file write enable
- writenum  input  3  destination register index
- data_in  input  16  write data
- start  input  1  begin operand fetch; sampled only in IDLE
- rn  input  3  index of register loaded into A
- rm  input  3  index of register loaded into B
- busy  output  1  high while a fetch is in progress (states READ_B, READ_A)
- done  output  1  one-cycle pulse when A and B are both valid
- a_out  output  16  operand register A
- b_out  output  16  operand register B, feeds the shifter input

Behaviour:
- Reset (asynchronous, active-high):
  - All 8 registers clear to 0; a_out = 0, b_out = 0.
  - done = 0, busy = 0, state = IDLE.
  - Reset asserted mid-fetch aborts the fetch: no done pulse, and A/B are cleared.
- Write port:
  - On each rising clk with write = 1, R[writenum] <= data_in.
  - The write port is independent of FSM state; writes are accepted in every state, including during a fetch.
- Read:
  - Combinational read of the array, mux-selected by the FSM (rm in READ_B, rn in READ_A).
- FSM states are IDLE, READ_B, READ_A, DONE.
  - IDLE: if start = 1, latch rn/rm into internal index registers and go to READ_B. Otherwise stay in IDLE.
  - READ_B: b_out <= R[rm_latched], go to READ_A.
  - READ_A: a_out <= R[rn_latched], go to DONE.
  - DONE: done = 1 for this cycle only, go to IDLE.
- Latency:
  - start sampled at edge 0; B updated at edge 1; A updated at edge 2.
  - done is high from edge 2 to edge 3.
  - A new start is accepted at the earliest in the cycle after DONE, i.e. one fetch per 4 cycles.
- start is ignored while busy or done; no queuing.
- rn/rm are latched at start, so changes to rn/rm mid-fetch have no effect.
- rn == rm is legal; A and B receive the same value.
- a_out and b_out hold their values between fetches and change only in READ_A and READ_B respectively.
- Read/write collision: a write to the register being read in the same cycle is read-before-write. The operand captures the old value and the array gets the new value, unless the optional feature below is enabled.
- No X propagation: every register has a reset value.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined: in READ_B or READ_A, if write = 1 and writenum equals the index being read, the operand register captures data_in (write-to-read forwarding). The array is still written.
- Undefined: read-before-write as stated above; no forwarding path is synthesized.

Decomposition:
- Shared package lab5_pkg holds:
  - DATA_W, REG_AW constants
  - typedef fetch_state_t enum {IDLE, READ_B, READ_A, DONE}, 2-bit encoding
  - typedef word_t logic [DATA_W-1:0]
- Natural sub-module: regfile. It contains the 8 x 16 array, one write port with a 3-to-8 one-hot write decoder, and one combinational read port selected by readnum.
- regfile_operand_fetch instantiates regfile and adds the FSM, the index latches, the A/B registers and the bypass mux.

Test Plan:
- Reset, then write R3 = 16'h1234 and R5 = 16'h00F0, then start with rn = 3, rm = 5:
  - busy is high for 2 cycles.
  - b_out = 16'h00F0 after edge 1; a_out = 16'h1234 after edge 2.
  - done pulses for exactly 1 cycle.
- During the fetch above, toggle rn/rm to 0 and raise start in READ_A:
  - The operands still come from R3/R5.
  - No second fetch starts, and only one done pulse occurs.
- rn = rm = 7 with R7 = 16'h8001:
  - a_out = b_out = 16'h8001, i.e. the shifter sees 16'h8001 on its input.
- Collision: R2 = 16'hAAAA; fetch with rm = 2 while writing R2 = 16'h5555 in the READ_B cycle:
  - Without RF_BYPASS_EN: b_out = 16'hAAAA.
  - With RF_BYPASS_EN: b_out = 16'h5555.
  - In both builds, a later fetch of R2 returns 16'h5555.
- Assert reset in the READ_A cycle:
  - a_out, b_out and all registers read 0.
  - done never pulses and busy falls immediately.
  - A start after reset is released completes normally.
- Back-to-back starts held high continuously:
  - done pulses every 4th cycle.
  - Each fetch reflects rn/rm as sampled in its IDLE cycle.

Source files
------------

// File: rtl/lab5_pkg.sv
// Shared types and constants for the register file and operand-fetch sequencer.
package lab5_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_B = 2'd1,
        READ_A = 2'd2,
        DONE   = 2'd3
    } fetch_state_t;

    function automatic logic [NREGS-1:0] decode_onehot(input logic [REG_AW-1:0] idx);
        logic [NREGS-1:0] v;
        v = {{(NREGS-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/regfile_operand_fetch_regfile.sv
// 8 x 16 register file: one one-hot-decoded write port, one combinational read port.
module regfile
    import lab5_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [REG_AW-1:0] writenum,
    input  word_t             data_in,
    input  logic [REG_AW-1:0] readnum,
    output word_t             data_out
);

    word_t            regs_r [NREGS];
    logic [NREGS-1:0] wr_sel_s;

    // Write decoder
    always_comb begin
        wr_sel_s = {NREGS{1'b0}};
        if (write) begin
            wr_sel_s = decode_onehot(writenum);
        end else begin
            wr_sel_s = {NREGS{1'b0}};
        end
    end

    // Register array storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_sel_s[i]) begin
                    regs_r[i] <= data_in;
                end
            end
        end
    end

    assign data_out = regs_r[readnum];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Register file plus operand-fetch FSM: loads B from R[rm], then A from R[rn], then pulses done.
// Optional build macro RF_BYPASS_EN adds write-to-read forwarding into the operand registers.
module regfile_operand_fetch
    import lab5_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [REG_AW-1:0] writenum,
    input  word_t             data_in,
    input  logic              start,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    output logic              busy,
    output logic              done,
    output word_t             a_out,
    output word_t             b_out
);

    fetch_state_t      state_r;
    logic [REG_AW-1:0] rn_r;
    logic [REG_AW-1:0] rm_r;
    logic [REG_AW-1:0] readnum_s;
    word_t             rd_data_s;
    word_t             operand_s;
    word_t             a_r;
    word_t             b_r;
    logic              busy_r;
    logic              done_r;

    regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .readnum  (readnum_s),
        .data_out (rd_data_s)
    );

    // Read index follows the fetch phase
    always_comb begin
        readnum_s = rm_r;
        if (state_r == READ_A) begin
            readnum_s = rn_r;
        end else begin
            readnum_s = rm_r;
        end
    end

    // Operand source: array read, optionally overridden by a same-cycle write
    always_comb begin
        operand_s = rd_data_s;
`ifdef RF_BYPASS_EN
        if (write && (writenum == readnum_s)) begin
            operand_s = data_in;
        end else begin
            operand_s = rd_data_s;
        end
`else
        operand_s = rd_data_s;
`endif
    end

    // Fetch sequencer with registered busy/done and operand registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            rn_r    <= {REG_AW{1'b0}};
            rm_r    <= {REG_AW{1'b0}};
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rn_r    <= rn;
                        rm_r    <= rm;
                        busy_r  <= 1'b1;
                        state_r <= READ_B;
                    end
                end
                READ_B: begin
                    b_r     <= operand_s;
                    state_r <= READ_A;
                end
                READ_A: begin
                    a_r     <= operand_s;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign a_out = a_r;
    assign b_out = b_r;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed self-checking bench for regfile_operand_fetch.
module tb_regfile_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        start;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic        busy;
    logic        done;
    logic [15:0] a_out;
    logic [15:0] b_out;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_mark;

    regfile_operand_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .start    (start),
        .rn       (rn),
        .rm       (rm),
        .busy     (busy),
        .done     (done),
        .a_out    (a_out),
        .b_out    (b_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
        write = 1'b1; writenum = idx; data_in = val;
        tick();
        write = 1'b0;
    endtask

    task automatic fetch(input logic [2:0] n, input logic [2:0] m);
        rn = n; rm = m; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; writenum = 3'd0; data_in = 16'h0000;
        start = 1'b0; rn = 3'd0; rm = 3'd0;
        tick();
        tick();
        check("rst_a", a_out, 16'h0000);
        check("rst_b", b_out, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0000);
        check("rst_done", {15'd0, done}, 16'h0000);
        reset = 1'b0;
        tick();

        // Basic fetch with mid-fetch index toggling and a stray start in READ_A
        write_reg(3'd3, 16'h1234);
        write_reg(3'd5, 16'h00F0);
        done_mark = done_cnt;
        rn = 3'd3; rm = 3'd5; start = 1'b1;
        tick();
        start = 1'b0; rn = 3'd0; rm = 3'd0;
        check("f1_busy_e0", {15'd0, busy}, 16'h0001);
        check("f1_b_e0", b_out, 16'h0000);
        tick();
        check("f1_b_e1", b_out, 16'h00F0);
        check("f1_busy_e1", {15'd0, busy}, 16'h0001);
        check("f1_done_e1", {15'd0, done}, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f1_a_e2", a_out, 16'h1234);
        check("f1_done_e2", {15'd0, done}, 16'h0001);
        check("f1_busy_e2", {15'd0, busy}, 16'h0000);
        tick();
        check("f1_done_e3", {15'd0, done}, 16'h0000);
        tick();
        tick();
        check("f1_no_refetch", {15'd0, busy}, 16'h0000);
        check("f1_one_done", done_cnt - done_mark, 16'd1);
        check("f1_a_hold", a_out, 16'h1234);
        check("f1_b_hold", b_out, 16'h00F0);

        // Same index on both operands
        write_reg(3'd7, 16'h8001);
        fetch(3'd7, 3'd7);
        check("same_a", a_out, 16'h8001);
        check("same_b", b_out, 16'h8001);

        // Read/write collision in READ_B
        write_reg(3'd2, 16'hAAAA);
        rn = 3'd0; rm = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        write = 1'b1; writenum = 3'd2; data_in = 16'h5555;
        tick();
        write = 1'b0;
`ifdef RF_BYPASS_EN
        check("coll_b", b_out, 16'h5555);
`else
        check("coll_b", b_out, 16'hAAAA);
`endif
        tick();
        check("coll_a", a_out, 16'h0000);
        tick();
        fetch(3'd2, 3'd2);
        check("coll_later_a", a_out, 16'h5555);
        check("coll_later_b", b_out, 16'h5555);

        // Reset asserted in READ_A aborts the fetch
        done_mark = done_cnt;
        rn = 3'd3; rm = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_b_pre", b_out, 16'h00F0);
        reset = 1'b1;
        #1;
        check("abort_a", a_out, 16'h0000);
        check("abort_b", b_out, 16'h0000);
        check("abort_busy", {15'd0, busy}, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("abort_no_done", done_cnt - done_mark, 16'd0);
        fetch(3'd3, 3'd5);
        check("abort_r3_clr", a_out, 16'h0000);
        check("abort_r5_clr", b_out, 16'h0000);
        check("abort_restart_done", done_cnt - done_mark, 16'd1);
        write_reg(3'd1, 16'h0BEE);
        fetch(3'd1, 3'd2);
        check("post_rst_a", a_out, 16'h0BEE);
        check("post_rst_b", b_out, 16'h0000);

        // Back-to-back starts held high
        write_reg(3'd4, 16'h4444);
        write_reg(3'd6, 16'h6666);
        rn = 3'd4; rm = 3'd6; start = 1'b1;
        tick();
        rn = 3'd6; rm = 3'd4;
        tick();
        tick();
        check("b2b_done_e2", {15'd0, done}, 16'h0001);
        check("b2b_a1", a_out, 16'h4444);
        check("b2b_b1", b_out, 16'h6666);
        tick();
        check("b2b_done_e3", {15'd0, done}, 16'h0000);
        tick();
        rn = 3'd1; rm = 3'd1;
        check("b2b_busy_e4", {15'd0, busy}, 16'h0001);
        tick();
        check("b2b_done_e5", {15'd0, done}, 16'h0000);
        check("b2b_b2", b_out, 16'h4444);
        tick();
        start = 1'b0;
        check("b2b_done_e6", {15'd0, done}, 16'h0001);
        check("b2b_a2", a_out, 16'h6666);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
